// File: rtl/fifo_rr_arb.sv
// Round-robin arbiter sharing one fifo input port between N_REQ pvld/prdy requesters,
// with bursts of up to MAX_BURST beats per grant and a single registered output stage.
module fifo_rr_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         in_pvld,
    input  logic [N_REQ*WIDTH-1:0]   in_pd,
    output logic [N_REQ-1:0]         in_prdy,
    output logic                     o_pvld,
    output logic [WIDTH-1:0]         o_pd,
    output logic [SRC_W-1:0]         o_src,
    input  logic                     o_prdy
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   owner_q, owner_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               o_pvld_q;
    logic [WIDTH-1:0]   o_pd_q;
    logic [SRC_W-1:0]   o_src_q;

    logic               load_en;
    logic               found;
    logic [SRC_W-1:0]   win;
    logic [SRC_W-1:0]   cand;
    int unsigned        idx;
    logic [N_REQ-1:0]   grant;
    logic               xfer;
    logic [SRC_W-1:0]   xsrc;
    logic [WIDTH-1:0]   pd_sel;
    logic [SRC_W-1:0]   win_nxt;
    logic [SRC_W-1:0]   owner_nxt;

    assign load_en = !o_pvld_q | o_prdy;

    // First valid requester scanning from ptr upwards, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = SRC_W'(idx);
            if (!found && in_pvld[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == StIdle) begin
            if (found) begin
                grant[win] = 1'b1;
            end
        end else begin
            grant[owner_q] = in_pvld[owner_q];
        end
    end

    // Held at zero during reset even though the IDLE scan would otherwise grant.
    assign in_prdy = {N_REQ{load_en & rst}} & grant;
    assign xfer    = |(in_pvld & in_prdy);
    assign xsrc    = (state_q == StIdle) ? win : owner_q;

    always_comb begin
        pd_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i == int'(xsrc)) begin
                pd_sel = in_pd[i*WIDTH +: WIDTH];
            end
        end
    end

    assign win_nxt   = (win == SRC_W'(N_REQ - 1)) ? '0 : win + SRC_W'(1);
    assign owner_nxt = (owner_q == SRC_W'(N_REQ - 1)) ? '0 : owner_q + SRC_W'(1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (MAX_BURST == 1) begin
                        ptr_d = win_nxt;
                    end else begin
                        state_d = StBurst;
                        owner_d = win;
                        cnt_d   = 8'd1;
                    end
                end
            end
            StBurst: begin
                // A stalled downstream holds the burst; only a free output stage can end it.
                if (load_en) begin
                    if (xfer) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_d == 8'(MAX_BURST)) begin
                            state_d = StIdle;
                            ptr_d   = owner_nxt;
                            cnt_d   = 8'd0;
                        end
                    end else begin
                        state_d = StIdle;
                        ptr_d   = owner_nxt;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            o_pvld_q <= 1'b0;
            o_pd_q   <= '0;
            o_src_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (load_en) begin
                o_pvld_q <= xfer;
                if (xfer) begin
                    o_pd_q  <= pd_sel;
                    o_src_q <= xsrc;
                end
            end
        end
    end

    assign o_pvld = o_pvld_q;
    assign o_pd   = o_pd_q;
    assign o_src  = o_src_q;

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Self-checking bench for fifo_rr_arb: directed scenarios plus randomized traffic against
// a transaction-level arbitration model.
module tb_fifo_rr_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  pvld = '0;
    logic [31:0] pd = '0;
    logic [3:0]  prdy;
    logic        ovld;
    logic [7:0]  opd;
    logic [1:0]  osrc;
    logic        oprdy = 1'b1;

    logic [3:0]  pvld1 = 4'b1001;
    logic [31:0] pd1 = 32'h3322_1100;
    logic [3:0]  prdy1;
    logic        ovld1;
    logic [7:0]  opd1;
    logic [1:0]  osrc1;

    int checks = 0;
    int errors = 0;

    // Reference model: owner < 0 means no burst in progress.
    int          m_owner = -1;
    int          m_ptr = 0;
    int          m_cnt = 0;
    logic        m_ovld = 1'b0;
    logic [7:0]  m_opd = '0;
    int          m_osrc = 0;
    int          last_x = -1;
    int          acc[4];
    logic [3:0]  ep;

    always #5 clk = ~clk;

    fifo_rr_arb #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_pvld (pvld),
        .in_pd   (pd),
        .in_prdy (prdy),
        .o_pvld  (ovld),
        .o_pd    (opd),
        .o_src   (osrc),
        .o_prdy  (oprdy)
    );

    fifo_rr_arb #(.N_REQ(N), .WIDTH(W), .MAX_BURST(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .in_pvld (pvld1),
        .in_pd   (pd1),
        .in_prdy (prdy1),
        .o_pvld  (ovld1),
        .o_pd    (opd1),
        .o_src   (osrc1),
        .o_prdy  (1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_prdy();
        logic [3:0] p;
        int         i;
        p = '0;
        if (rst && (!m_ovld || oprdy)) begin
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr + k) % N;
                    if (pvld[i] && p == 4'b0) p[i] = 1'b1;
                end
            end else if (pvld[m_owner]) begin
                p[m_owner] = 1'b1;
            end
        end
        return p;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_ovld  = 1'b0;
        m_opd   = '0;
        m_osrc  = 0;
        last_x  = -1;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        int          x;
        logic        le;
        logic [31:0] pd_s;
        #1;
        ep = model_prdy();
        chk("in_prdy", 32'(prdy), 32'(ep));
        x = -1;
        for (int i = 0; i < N; i++) if (ep[i] && pvld[i]) x = i;
        le   = !m_ovld || oprdy;
        pd_s = pd;
        if (ovld && oprdy) acc[osrc]++;
        @(posedge clk);
        if (rst) begin
            if (le) begin
                m_ovld = (x >= 0);
                if (x >= 0) begin
                    m_opd  = pd_s[x*8 +: 8];
                    m_osrc = x;
                end
            end
            if (m_owner < 0) begin
                if (x >= 0) begin
                    m_owner = x;
                    m_cnt   = 1;
                end
            end else if (le) begin
                if (x >= 0) m_cnt++;
                if (x < 0 || m_cnt == MB) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
        end
        last_x = x;
        @(negedge clk);
        chk("o_pvld", 32'(ovld), 32'(m_ovld));
        chk("o_pd", 32'(opd), 32'(m_opd));
        chk("o_src", 32'(osrc), 32'(m_osrc));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    int rot[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};

    initial begin
        // Reset held with every requester valid.
        pvld = 4'hF;
        pd   = 32'hA3A2_A1A0;
        rst  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_prdy", 32'(prdy), 32'h0);
            chk("rst_pvld", 32'(ovld), 32'h0);
            chk("rst_src", 32'(osrc), 32'h0);
            chk("rst_pvld1", 32'(ovld1), 32'h0);
        end
        rst = 1'b1;
        model_reset();
        #1 chk("first_grant", 32'(prdy), 32'h1);

        // Burst rotation on dut, per-beat alternation with ptr wrap on dut1.
        for (int k = 0; k < 17; k++) begin
            step();
            chk("rot_pvld", 32'(ovld), 32'h1);
            chk("rot_src", 32'(osrc), 32'(rot[k]));
            chk("rot_pd", 32'(opd), 32'(8'hA0 + rot[k]));
            chk("pb_pvld", 32'(ovld1), 32'h1);
            chk("pb_src", 32'(osrc1), (k % 2 == 0) ? 32'd0 : 32'd3);
            chk("pb_pd", 32'(opd1), (k % 2 == 0) ? 32'h00 : 32'h33);
        end

        // Early burst end: requester 1 gives two beats, then requester 2 after one bubble.
        do_reset();
        pvld = 4'b0010;
        pd   = 32'h0000_1100;
        step();
        chk("early_src_a", 32'(osrc), 32'd1);
        step();
        chk("early_src_b", 32'(osrc), 32'd1);
        pvld = 4'b0100;
        pd   = 32'h0022_0000;
        step();
        chk("early_bubble", 32'(ovld), 32'h0);
        step();
        chk("early_next_pvld", 32'(ovld), 32'h1);
        chk("early_next_src", 32'(osrc), 32'd2);
        chk("early_next_pd", 32'(opd), 32'h22);

        // Backpressure mid-burst.
        do_reset();
        pvld = 4'hF;
        pd   = 32'hA3A2_A1A0;
        for (int i = 0; i < 4; i++) acc[i] = 0;
        step();
        step();
        oprdy = 1'b0;
        repeat (5) begin
            step();
            chk("bp_pvld", 32'(ovld), 32'h1);
            chk("bp_pd", 32'(opd), 32'hA0);
            chk("bp_src", 32'(osrc), 32'd0);
            chk("bp_prdy", 32'(prdy), 32'h0);
        end
        oprdy = 1'b1;
        repeat (5) step();
        chk("bp_beats", 32'(acc[0]), 32'd4);

        // Asynchronous reset between edges while a beat is held.
        do_reset();
        pvld = 4'hF;
        step();
        step();
        chk("ar_pre_pvld", 32'(ovld), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("ar_pvld", 32'(ovld), 32'h0);
        chk("ar_prdy", 32'(prdy), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1 chk("ar_grant", 32'(prdy), 32'h1);
        step();
        chk("ar_src", 32'(osrc), 32'd0);

        // Randomized traffic with protocol-respecting sources.
        do_reset();
        pvld = '0;
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (last_x == i || !pvld[i]) begin
                    pvld[i]       = ($urandom_range(0, 3) != 0);
                    pd[i*8 +: 8]  = 8'($urandom);
                end
            end
            oprdy = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arb.md
Name: fifo_rr_arb

Overview:
- Round-robin arbiter that shares one fifo input port between N_REQ requesters using the pvld/prdy/pd handshake.
- A granted requester may hold the port for a burst of up to MAX_BURST beats.
- A single registered output stage drives the fifo's in_pvld/in_pd and accepts the fifo's in_prdy as o_prdy.
- o_src tags each beat with its requester index.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, payload width per requester.
- MAX_BURST, 4, maximum consecutive beats per grant (1..255); 1 means pure per-beat round robin.
- SRC_W, $clog2(N_REQ) (minimum 1), width of o_src; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_pvld  in  N_REQ  per-requester valid.
- in_pd  in  N_REQ*WIDTH  packed payloads; requester i occupies [i*WIDTH +: WIDTH].
- in_prdy  out  N_REQ  per-requester ready; at most one bit high per cycle.
- o_pvld  out  1  output valid (registered).
- o_pd  out  WIDTH  output payload (registered).
- o_src  out  SRC_W  index of the requester that supplied o_pd (registered).
- o_prdy  in  1  downstream ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_pvld=0, o_pd=0, o_src=0.
  - state=IDLE, owner=0, ptr=0, cnt=0.
  - in_prdy=0 while rst=0.
- Output stage:
  - load_en = !o_pvld | o_prdy.
  - A transfer from requester i occurs when in_pvld[i] & in_prdy[i].
  - On transfer: o_pvld<=1, o_pd<=in_pd[i], o_src<=i.
  - If load_en and no transfer: o_pvld<=0; o_pd and o_src hold.
  - If o_pvld & !o_prdy: all output registers hold. No beat is dropped or duplicated.
- in_prdy[i] = load_en & grant[i]. It is combinational from state, in_pvld and o_prdy, and must not depend on in_prdy.
- Latency: one cycle from input handshake to o_pvld. Full throughput of one beat per cycle while o_prdy=1.
- States:
  - IDLE:
    - grant goes to the first i with in_pvld[i]=1, scanning ptr, ptr+1, ... modulo N_REQ.
    - No request: no grant, no state change.
    - On transfer from winner w with MAX_BURST=1: stay IDLE, ptr<=(w+1) mod N_REQ.
    - On transfer with MAX_BURST>1: go to BURST, owner<=w, cnt<=1.
    - If !load_en: a grant may be shown, but in_prdy=0 and nothing changes.
  - BURST:
    - grant only to owner; all other in_prdy=0.
    - If load_en & in_pvld[owner]: transfer and cnt<=cnt+1. If cnt+1==MAX_BURST: go to IDLE, ptr<=(owner+1) mod N_REQ.
    - If load_en & !in_pvld[owner]: burst ends, no transfer this cycle (one bubble), go to IDLE, ptr<=(owner+1) mod N_REQ.
    - If !load_en: hold state. A stalled downstream never ends a burst, and the owner may keep pvld high across the stall.
- Fairness:
  - ptr always moves to one past the last owner, so each requester waits at most (N_REQ-1) bursts.
  - ptr wraps from N_REQ-1 to 0.
- Input protocol: a requester holding pvld=1 without ready must keep pd stable. The arbiter does not check this.
- cnt is 8 bits and is only compared against MAX_BURST. It resets to 0 on leaving BURST.
- Reset mid-burst: all state returns to reset values immediately. Any beat in the output register is discarded (o_pvld=0).

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_pvld=4'b1111 -> in_prdy=0, o_pvld=0, o_src=0. After release, the first grant goes to requester 0.
- Burst rotation (MAX_BURST=4, o_prdy=1, all requesters always valid, pd[i]=8'hA0+i) -> o_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; no gaps in o_pvld.
- Early burst end: requester 1 valid for 2 beats then drops, requester 2 valid -> o_src 1,1, one cycle with o_pvld=0, then 2.
- Backpressure: o_prdy=0 for 5 cycles mid-burst -> o_pvld, o_pd, o_src stable. All in_prdy=0 while o_pvld=1. Burst resumes and completes with a total of 4 beats, none lost.
- Per-beat mode (MAX_BURST=1): requesters 0 and 3 always valid -> o_src alternates 0,3,0,3. ptr wrap is checked.
- Async reset mid-burst: assert rst=0 between clock edges with o_pvld=1 -> o_pvld drops before the next edge. After release the grant restarts at ptr=0.
